// File: rtl/famicom_input_serializer_if.sv
// Host-side signal bundle for the Famicom input serializer: pad, keystroke entry,
// Gigatron latch/pulse/data and key store status.
interface famicom_input_serializer_if;
  logic [15:0] joystick;
  logic [7:0]  key_code;
  logic        key_valid;
  logic        famicom_latch;
  logic        famicom_pulse;
  logic        famicom_data;
  logic        key_busy;
  logic        key_full;
  logic        key_drop;

  modport master (
    output joystick, key_code, key_valid, famicom_latch, famicom_pulse,
    input  famicom_data, key_busy, key_full, key_drop
  );

  modport slave (
    input  joystick, key_code, key_valid, famicom_latch, famicom_pulse,
    output famicom_data, key_busy, key_full, key_drop
  );
endinterface

// File: rtl/famicom_input_serializer.sv
// Presents a joystick and ASCII keystrokes to the Gigatron as a Famicom pad shift register.
// Define FAMICOM_KEY_FIFO_EN for a 4-entry key FIFO; otherwise a single overwriting key register.
module famicom_input_serializer #(
  parameter int KEY_HOLD = 3,
  parameter int KEY_GAP  = 1
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  famicom_input_serializer_if.slave    bus
);

  localparam logic [3:0] HOLD_INIT = 4'(KEY_HOLD);
  localparam logic [3:0] GAP_INIT  = 4'(KEY_GAP);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} seq_state_t;

  seq_state_t state_reg, state_next;
  logic [3:0] count_reg, count_next;
  logic [7:0] cur_key_reg, cur_key_next;
  logic       pop;
  logic       store_empty;
  logic       store_full;
  logic [7:0] store_data;

  logic latch_meta_reg, latch_sync_reg, latch_prev_reg;
  logic pulse_meta_reg, pulse_sync_reg, pulse_prev_reg;
  logic frame_event;
  logic pulse_rise;

  logic [7:0] shift_reg;
  logic [7:0] pad_byte;
  logic [7:0] key_rev;
  logic [7:0] key_byte;

  logic unused_joystick_hi;
  assign unused_joystick_hi = ^bus.joystick[15:8];

  // Latch and pulse come from the Gigatron clock domain.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      latch_meta_reg <= 1'b0;
      latch_sync_reg <= 1'b0;
      latch_prev_reg <= 1'b0;
      pulse_meta_reg <= 1'b0;
      pulse_sync_reg <= 1'b0;
      pulse_prev_reg <= 1'b0;
    end else begin
      latch_meta_reg <= bus.famicom_latch;
      latch_sync_reg <= latch_meta_reg;
      latch_prev_reg <= latch_sync_reg;
      pulse_meta_reg <= bus.famicom_pulse;
      pulse_sync_reg <= pulse_meta_reg;
      pulse_prev_reg <= pulse_sync_reg;
    end
  end

  assign frame_event = latch_prev_reg & ~latch_sync_reg;
  assign pulse_rise  = pulse_sync_reg & ~pulse_prev_reg;

  // A leaves first so it lands in the Gigatron's bit 7.
  assign pad_byte = ~{bus.joystick[0], bus.joystick[1], bus.joystick[2], bus.joystick[3],
                      bus.joystick[7], bus.joystick[6], bus.joystick[5], bus.joystick[4]};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_key_rev
      assign key_rev[gi] = cur_key_reg[7 - gi];
    end
  endgenerate

  assign key_byte = (state_reg == HOLD) ? key_rev : 8'hFF;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      shift_reg <= 8'hFF;
    end else if (latch_sync_reg) begin
      shift_reg <= pad_byte & key_byte;
    end else if (pulse_rise) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  assign bus.famicom_data = shift_reg[0];
  assign bus.key_busy     = (state_reg != IDLE);
  assign bus.key_full     = store_full;

`ifdef FAMICOM_KEY_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_reg;
  logic [1:0] rd_ptr_reg;
  logic [2:0] fill_reg;
  logic       key_drop_reg;
  logic       push;

  assign store_full  = (fill_reg == 3'd4);
  assign store_empty = (fill_reg == 3'd0);
  assign store_data  = fifo_mem[rd_ptr_reg];
  // A full store still accepts a key when an entry leaves in the same cycle.
  assign push        = bus.key_valid && (!store_full || pop);

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= bus.key_code;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      key_drop_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_reg + 2'(push);
      rd_ptr_reg   <= rd_ptr_reg + 2'(pop);
      fill_reg     <= fill_reg + 3'(push) - 3'(pop);
      key_drop_reg <= bus.key_valid && !push;
    end
  end

  assign bus.key_drop = key_drop_reg;
`else
  logic [7:0] key_store_reg;
  logic       key_occ_reg;

  // A newer keystroke replaces an unsent one; a simultaneous pop takes the old value.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_store_reg <= '0;
      key_occ_reg   <= 1'b0;
    end else if (bus.key_valid) begin
      key_store_reg <= bus.key_code;
      key_occ_reg   <= 1'b1;
    end else if (pop) begin
      key_occ_reg   <= 1'b0;
    end
  end

  assign store_full   = key_occ_reg;
  assign store_empty  = !key_occ_reg;
  assign store_data   = key_store_reg;
  assign bus.key_drop = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      cur_key_reg <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      cur_key_reg <= cur_key_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    cur_key_next = cur_key_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        // Key entry waits for latch low so a load never sees K change mid-latch.
        if (!store_empty && !latch_sync_reg) begin
          pop          = 1'b1;
          state_next   = HOLD;
          count_next   = HOLD_INIT;
          cur_key_next = store_data;
        end
      end
      HOLD: begin
        if (frame_event) begin
          if (count_reg <= 4'd1) begin
            if (GAP_INIT != 4'd0) begin
              state_next = GAP;
              count_next = GAP_INIT;
            end else if (!store_empty) begin
              pop          = 1'b1;
              state_next   = HOLD;
              count_next   = HOLD_INIT;
              cur_key_next = store_data;
            end else begin
              state_next = IDLE;
              count_next = '0;
            end
          end else begin
            count_next = count_reg - 4'd1;
          end
        end
      end
      GAP: begin
        if (frame_event) begin
          if (count_reg <= 4'd1) begin
            state_next = IDLE;
            count_next = '0;
          end else begin
            count_next = count_reg - 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

endmodule
